road_renderer: RTL and testbench
================================

// Module: road_renderer
// PURPOSE
//  Pixel generator directly downstream of the VGA timing generator. Consumes its
//  registered x/y/blank_n/HS/VS and produces 24-bit RGB for the racing game:
//  grass, road, scrolling dashed lane marks, player car and one falling obstacle.
//  Game state (scroll, car_x, obstacle, collision) updates once per frame.
// PARAMETERS
//  ROAD_LEFT   200  first road column (px)
//  ROAD_RIGHT  440  first grass column right of road (px)
//  CAR_Y       400  car top row; car occupies rows CAR_Y..CAR_Y+CAR_H-1
//  CAR_W/CAR_H 32/48 car sprite size (px)
//  OBS_W/OBS_H 32/48 obstacle sprite size (px)
//  LANE_PERIOD 64   dash period in rows (power of 2)
//  LANE_DASH   32   visible rows per dash period
//  STEP        4    car horizontal move per frame (px)
// PORTS
//  vga_clk    in  1   pixel clock (25 MHz), sole clock
//  reset      in  1   asynchronous, active-low (0 = reset)
//  blank_n    in  1   active-video flag, aligned with x/y
//  HS, VS     in  1   syncs from timing generator, active-low pulses
//  x          in  10  pixel column 0..639
//  y          in  9   pixel row 0..479
//  btn_left   in  1   level, move car left
//  btn_right  in  1   level, move car right
//  speed      in  3   scroll/obstacle px per frame; 0 = stopped
//  restart    in  1   one-cycle pulse: clear game over, re-init state
//  R, G, B    out 8   colour, 1-cycle latency
//  blank_n_o, HS_o, VS_o out 1  inputs delayed 1 cycle (aligned to RGB)
//  collision  out 1   sticky game-over flag
// BEHAVIOUR
//  Reset (reset=0): R/G/B=0, blank_n_o=0, HS_o=VS_o=1, collision=0, scroll=0,
//   car_x=304, obs_y=0, obs_lane=1, lfsr=8'hA5.
//  frame_tick: 1-cycle pulse on VS 1->0 (VS registered into vs_d; tick=vs_d&~VS).
//  On frame_tick, collision=0:
//   - scroll <= (scroll + speed) mod LANE_PERIOD.
//   - btn_left only: car_x <= max(car_x-STEP, ROAD_LEFT); btn_right only:
//     car_x <= min(car_x+STEP, ROAD_RIGHT-CAR_W); both/neither: hold.
//   - if obs_y+speed >= 480: obs_y<=0, lfsr steps (x^8+x^6+x^5+x^4+1, shift
//     left, feedback into bit0), obs_lane <= lfsr_next[1:0]==3 ? 1 : [1:0].
//     else obs_y <= obs_y+speed. Sum computed 10-bit, no overflow.
//  On frame_tick with collision=1: all game state holds (frozen frame).
//  Lanes: centres 240/320/400; obstacle left edge 224/304/384 for lane 0/1/2.
//  Pixel classes (combinational on x,y; registered into RGB), priority high->low:
//   car      x in [car_x,car_x+CAR_W), y in [CAR_Y,CAR_Y+CAR_H)   -> FF0000
//   obstacle x in [obs_x,obs_x+OBS_W), y in [obs_y,obs_y+OBS_H)   -> FFFF00
//   mark     x in [278,282)or[358,362), ((y+scroll)&(P-1))<DASH  -> FFFFFF
//   road     x in [ROAD_LEFT,ROAD_RIGHT)                         -> 404040
//   grass    otherwise                                           -> 00A000
//  blank_n=0 -> RGB=0 regardless of class. Obstacle rows >=480 simply not shown.
//  Collision: any cycle with blank_n=1 and pixel in both car and obstacle
//   rectangles sets collision next cycle; stays 1 until restart.
//  restart=1: collision<=0, scroll/car_x/obs_y/obs_lane to reset values (lfsr
//   kept). restart wins over simultaneous frame_tick and collision detection.
//  Async reset mid-frame: state re-inits immediately; first tick at next VS fall.
// CONFIGURATION
//  ROAD_SCORE_EN defined: output port score[15:0]; reset/restart -> 0; +1 on each
//   obstacle wrap while collision=0; wraps FFFF->0000.
//  Undefined: no score port, no counter logic.
// TESTING
//  Reset low 5 cycles -> RGB=0, collision=0; then x=320,y=200,blank_n=1 -> 404040.
//  blank_n=0 at x=100,y=100 -> RGB=000000 next cycle; blank_n=1 -> 00A000.
//  btn_left held 30 frames from 304 -> car_x 200 after 26 frames, holds at 200.
//  speed=4, 120 frames -> obs_y wraps to 0, lane from lfsr; score=1 if _EN.
//  speed=0, btn_left to move car into lane 0 before obstacle lane 0 reaches row
//   400 (force lane) -> collision=1; further frames frozen; restart -> car_x=304.
//  restart and frame_tick same cycle with collision=1 -> collision=0, obs_y=0.

Source files
------------

// File: rtl/road_renderer.sv
// road_renderer: pixel generator for the racing game, fed by the VGA timing
// generator. Classifies each pixel as car / obstacle / lane mark / road / grass
// and registers the colour with one cycle of latency. The game state (scroll,
// car position, falling obstacle, collision) advances once per frame on the
// falling edge of VS.
// Optional feature: define ROAD_SCORE_EN to add a 16-bit score output that
// counts obstacles dodged.
module road_renderer #(
    parameter logic [9:0] ROAD_LEFT   = 10'd200,
    parameter logic [9:0] ROAD_RIGHT  = 10'd440,
    parameter logic [9:0] CAR_Y       = 10'd400,
    parameter logic [9:0] CAR_W       = 10'd32,
    parameter logic [9:0] CAR_H       = 10'd48,
    parameter logic [9:0] OBS_W       = 10'd32,
    parameter logic [9:0] OBS_H       = 10'd48,
    parameter logic [9:0] LANE_PERIOD = 10'd64,
    parameter logic [9:0] LANE_DASH   = 10'd32,
    parameter logic [9:0] STEP        = 10'd4
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       blank_n,
    input  logic       HS,
    input  logic       VS,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [2:0] speed,
    input  logic       restart,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       blank_n_o,
    output logic       HS_o,
    output logic       VS_o,
    output logic       collision
`ifdef ROAD_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    localparam logic [9:0]  SCREEN_H  = 10'd480;
    localparam logic [9:0]  CAR_X0    = ((ROAD_LEFT + ROAD_RIGHT) >> 1) - (CAR_W >> 1);
    localparam logic [9:0]  CAR_X_MAX = ROAD_RIGHT - CAR_W;
    localparam logic [9:0]  OBS_X0    = 10'd240 - (OBS_W >> 1);
    localparam logic [9:0]  OBS_X1    = 10'd320 - (OBS_W >> 1);
    localparam logic [9:0]  OBS_X2    = 10'd400 - (OBS_W >> 1);
    localparam logic [9:0]  MARK0_L   = 10'd278;
    localparam logic [9:0]  MARK1_L   = 10'd358;
    localparam logic [9:0]  MARK_W    = 10'd4;
    localparam logic [23:0] COL_CAR   = 24'hFF0000;
    localparam logic [23:0] COL_OBS   = 24'hFFFF00;
    localparam logic [23:0] COL_MARK  = 24'hFFFFFF;
    localparam logic [23:0] COL_ROAD  = 24'h404040;
    localparam logic [23:0] COL_GRASS = 24'h00A000;

    logic [9:0]  scroll;
    logic [9:0]  car_x;
    logic [9:0]  obs_y;
    logic [1:0]  obs_lane;
    logic [7:0]  lfsr;
    logic        vs_d;

    logic        frame_tick;
    logic [7:0]  lfsr_nxt;
    logic [9:0]  obs_sum;
    logic        obs_wrap;
    logic [9:0]  obs_x;
    logic [9:0]  y10;
    logic [9:0]  lane_row;
    logic        in_car_p0;
    logic        in_obs_p0;
    logic        in_mark_p0;
    logic        in_road_p0;
    logic        hit_p0;
    logic [23:0] rgb_p0;

    assign frame_tick = vs_d & ~VS;
    assign lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign obs_sum    = obs_y + {7'b0, speed};
    assign obs_wrap   = (obs_sum >= SCREEN_H);
    assign y10        = {1'b0, y};
    assign lane_row   = (y10 + scroll) & (LANE_PERIOD - 10'd1);
    assign VS_o       = vs_d;

    // Obstacle left edge for the current lane (lane 3 never occurs).
    always_comb begin
        case (obs_lane)
            2'd0:    obs_x = OBS_X0;
            2'd2:    obs_x = OBS_X2;
            default: obs_x = OBS_X1;
        endcase
    end

    // ---- stage p0: classify the current pixel and pick its colour ----
    always_comb begin
        in_car_p0  = (x >= car_x) && ({1'b0, x} < ({1'b0, car_x} + {1'b0, CAR_W})) &&
                     (y10 >= CAR_Y) && ({1'b0, y10} < ({1'b0, CAR_Y} + {1'b0, CAR_H}));
        in_obs_p0  = (x >= obs_x) && ({1'b0, x} < ({1'b0, obs_x} + {1'b0, OBS_W})) &&
                     (y10 >= obs_y) && ({1'b0, y10} < ({1'b0, obs_y} + {1'b0, OBS_H}));
        in_mark_p0 = (((x >= MARK0_L) && (x < MARK0_L + MARK_W)) ||
                      ((x >= MARK1_L) && (x < MARK1_L + MARK_W))) &&
                     (lane_row < LANE_DASH);
        in_road_p0 = (x >= ROAD_LEFT) && (x < ROAD_RIGHT);
        hit_p0     = blank_n & in_car_p0 & in_obs_p0;

        rgb_p0 = COL_GRASS;
        if (in_car_p0)       rgb_p0 = COL_CAR;
        else if (in_obs_p0)  rgb_p0 = COL_OBS;
        else if (in_mark_p0) rgb_p0 = COL_MARK;
        else if (in_road_p0) rgb_p0 = COL_ROAD;
        if (!blank_n)        rgb_p0 = 24'h0;
    end

    // ---- stage p1: register colour and delay syncs to stay aligned ----
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            R         <= 8'h0;
            G         <= 8'h0;
            B         <= 8'h0;
            blank_n_o <= 1'b0;
            HS_o      <= 1'b1;
            vs_d      <= 1'b1;
        end else begin
            {R, G, B} <= rgb_p0;
            blank_n_o <= blank_n;
            HS_o      <= HS;
            vs_d      <= VS;
        end
    end

    // Game state: per-frame update, sticky collision, restart re-init (LFSR kept).
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            collision <= 1'b0;
            scroll    <= 10'd0;
            car_x     <= CAR_X0;
            obs_y     <= 10'd0;
            obs_lane  <= 2'd1;
            lfsr      <= 8'hA5;
        end else if (restart) begin
            collision <= 1'b0;
            scroll    <= 10'd0;
            car_x     <= CAR_X0;
            obs_y     <= 10'd0;
            obs_lane  <= 2'd1;
        end else begin
            if (hit_p0)
                collision <= 1'b1;
            if (frame_tick && !collision) begin
                scroll <= (scroll + {7'b0, speed}) & (LANE_PERIOD - 10'd1);
                if (btn_left && !btn_right) begin
                    if (car_x < ROAD_LEFT + STEP) car_x <= ROAD_LEFT;
                    else                          car_x <= car_x - STEP;
                end else if (btn_right && !btn_left) begin
                    if (car_x + STEP > CAR_X_MAX) car_x <= CAR_X_MAX;
                    else                          car_x <= car_x + STEP;
                end
                if (obs_wrap) begin
                    obs_y    <= 10'd0;
                    lfsr     <= lfsr_nxt;
                    obs_lane <= (lfsr_nxt[1:0] == 2'd3) ? 2'd1 : lfsr_nxt[1:0];
                end else begin
                    obs_y <= obs_sum;
                end
            end
        end
    end

`ifdef ROAD_SCORE_EN
    // Score counts obstacles that wrapped off the bottom while still alive.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset)
            score <= 16'h0;
        else if (restart)
            score <= 16'h0;
        else if (frame_tick && !collision && obs_wrap)
            score <= score + 16'h1;
    end
`endif

endmodule

// File: tb/tb_road_renderer.sv
// Directed bench for road_renderer: frames are emulated by short VS pulses so
// that many game frames fit in a few hundred clock cycles.
module tb_road_renderer;

    logic       vga_clk;
    logic       reset;
    logic       blank_n;
    logic       HS;
    logic       VS;
    logic [9:0] x;
    logic [8:0] y;
    logic       btn_left;
    logic       btn_right;
    logic [2:0] speed;
    logic       restart;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       blank_n_o;
    logic       HS_o;
    logic       VS_o;
    logic       collision;
`ifdef ROAD_SCORE_EN
    logic [15:0] score;
`endif

    int n_cmp;
    int n_err;

    road_renderer dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .blank_n   (blank_n),
        .HS        (HS),
        .VS        (VS),
        .x         (x),
        .y         (y),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .speed     (speed),
        .restart   (restart),
        .R         (R),
        .G         (G),
        .B         (B),
        .blank_n_o (blank_n_o),
        .HS_o      (HS_o),
        .VS_o      (VS_o),
        .collision (collision)
`ifdef ROAD_SCORE_EN
        ,
        .score     (score)
`endif
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Emulated frames: VS low for one cycle gives exactly one tick.
    task automatic frames(input int n);
        repeat (n) begin
            VS = 1'b0;
            step();
            VS = 1'b1;
            step();
        end
    endtask

    task automatic pix(input string tag, input logic [9:0] px, input logic [8:0] py,
                       input logic bn, input logic [23:0] exp);
        x = px;
        y = py;
        blank_n = bn;
        step();
        chk(tag, 32'({R, G, B}), 32'(exp));
        blank_n = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        blank_n = 1'b1;
        HS = 1'b1;
        VS = 1'b1;
        x = 10'd320;
        y = 9'd200;
        btn_left = 1'b0;
        btn_right = 1'b0;
        speed = 3'd0;
        restart = 1'b0;

        // Reset state
        repeat (5) step();
        chk("rst_rgb", 32'({R, G, B}), 32'h0);
        chk("rst_coll", 32'(collision), 32'h0);
        chk("rst_blank", 32'(blank_n_o), 32'h0);
        chk("rst_vs", 32'(VS_o), 32'h1);
        chk("rst_carx", 32'(dut.car_x), 32'd304);
        reset = 1'b1;
        step();
        chk("road_px", 32'({R, G, B}), 32'h404040);
        chk("blank_o", 32'(blank_n_o), 32'h1);
        HS = 1'b0;
        step();
        chk("hs_o", 32'(HS_o), 32'h0);
        HS = 1'b1;

        // Blanking and basic classes, scroll = 0
        pix("blank_px", 10'd100, 9'd100, 1'b0, 24'h000000);
        pix("grass_px", 10'd100, 9'd100, 1'b1, 24'h00A000);
        pix("mark_a", 10'd280, 9'd10, 1'b1, 24'hFFFFFF);
        pix("mark_gap", 10'd281, 9'd40, 1'b1, 24'h404040);
        pix("mark_edge", 10'd282, 9'd10, 1'b1, 24'h404040);
        pix("mark_b", 10'd358, 9'd31, 1'b1, 24'hFFFFFF);
        pix("obs_px", 10'd310, 9'd10, 1'b1, 24'hFFFF00);
        pix("car_px", 10'd310, 9'd410, 1'b1, 24'hFF0000);

        // Steering to the left limit
        btn_left = 1'b1;
        frames(26);
        chk("left_26", 32'(dut.car_x), 32'd200);
        frames(4);
        chk("left_hold", 32'(dut.car_x), 32'd200);
        btn_left = 1'b0;
        pix("car_left", 10'd200, 9'd400, 1'b1, 24'hFF0000);
        pix("grass_left", 10'd199, 9'd400, 1'b1, 24'h00A000);

        // Steering to the right limit
        btn_right = 1'b1;
        frames(60);
        chk("right_max", 32'(dut.car_x), 32'd408);
        btn_right = 1'b0;
        pix("car_right", 10'd439, 9'd447, 1'b1, 24'hFF0000);
        pix("grass_right", 10'd440, 9'd447, 1'b1, 24'h00A000);

        // Restart pulse re-centres the car
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_carx", 32'(dut.car_x), 32'd304);

        // Obstacle fall and wrap at speed 4
        speed = 3'd4;
        frames(119);
        chk("obs_476", 32'(dut.obs_y), 32'd476);
        frames(1);
        chk("obs_wrap", 32'(dut.obs_y), 32'd0);
        chk("lane_wrap1", 32'(dut.obs_lane), 32'd2);
        chk("coll_blank", 32'(collision), 32'h0);
`ifdef ROAD_SCORE_EN
        chk("score_1", 32'(score), 32'd1);
`endif
        // scroll is now 480 mod 64 = 32
        pix("scroll_gap", 10'd280, 9'd0, 1'b1, 24'h404040);
        pix("scroll_dash", 10'd280, 9'd32, 1'b1, 24'hFFFFFF);
        pix("obs_l2", 10'd384, 9'd0, 1'b1, 24'hFFFF00);
        pix("obs_l2_left", 10'd383, 9'd0, 1'b1, 24'h404040);
        pix("obs_l2_corner", 10'd415, 9'd47, 1'b1, 24'hFFFF00);
        pix("obs_l2_below", 10'd415, 9'd48, 1'b1, 24'h404040);

        // Steer into lane 2, let the obstacle fall onto the car
        speed = 3'd0;
        btn_right = 1'b1;
        frames(20);
        btn_right = 1'b0;
        chk("car_lane2", 32'(dut.car_x), 32'd384);
        speed = 3'd4;
        frames(100);
        chk("obs_400", 32'(dut.obs_y), 32'd400);
        pix("overlap_blank", 10'd390, 9'd410, 1'b0, 24'h000000);
        chk("no_coll_blank", 32'(collision), 32'h0);
        pix("overlap_px", 10'd390, 9'd410, 1'b1, 24'hFF0000);
        chk("coll_set", 32'(collision), 32'h1);

        // Frozen frames after game over
        btn_left = 1'b1;
        frames(3);
        btn_left = 1'b0;
        chk("frz_carx", 32'(dut.car_x), 32'd384);
        chk("frz_obsy", 32'(dut.obs_y), 32'd400);
        chk("coll_sticky", 32'(collision), 32'h1);

        // Restart coinciding with a frame tick
        VS = 1'b0;
        restart = 1'b1;
        step();
        VS = 1'b1;
        restart = 1'b0;
        chk("rt_coll", 32'(collision), 32'h0);
        chk("rt_obsy", 32'(dut.obs_y), 32'd0);
        chk("rt_carx", 32'(dut.car_x), 32'd304);
        chk("rt_lane", 32'(dut.obs_lane), 32'd1);
        step();

        // Second wrap: LFSR kept across restart, 4A -> 95 gives lane 1
        frames(120);
        chk("obs_wrap2", 32'(dut.obs_y), 32'd0);
        chk("lane_wrap2", 32'(dut.obs_lane), 32'd1);
`ifdef ROAD_SCORE_EN
        chk("score_rt", 32'(score), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
